// File: rtl/avmm_cfg_arbiter_if.sv
// Signal bundle for avmm_cfg_arbiter: requester-side AVMM ports, the single
// downstream AVMM port and arbiter status. The _i/_o suffixes are relative to
// the arbiter, so the arbiter uses the slave modport and its environment
// (requesters, downstream target, monitors) uses the master modport.
interface avmm_cfg_arbiter_if #(
    parameter int NUM_REQ = 2
);
    // Requester side; requester k occupies slice k of each packed field
    logic [NUM_REQ-1:0]    req_write_i;
    logic [NUM_REQ-1:0]    req_read_i;
    logic [NUM_REQ*17-1:0] req_address_i;
    logic [NUM_REQ*32-1:0] req_writedata_i;
    logic [NUM_REQ*4-1:0]  req_byteenable_i;
    logic [NUM_REQ-1:0]    req_waitrequest_o;
    logic [31:0]           req_readdata_o;

    // Downstream side
    logic                  avmm_write_o;
    logic                  avmm_read_o;
    logic [16:0]           avmm_address_o;
    logic [31:0]           avmm_writedata_o;
    logic [3:0]            avmm_byteenable_o;
    logic                  avmm_waitrequest_i;
    logic [31:0]           avmm_readdata_i;

    // Status
    logic [NUM_REQ-1:0]    grant_o;
    logic                  timeout_err_o;

    modport slave (
        input  req_write_i, req_read_i, req_address_i, req_writedata_i,
               req_byteenable_i, avmm_waitrequest_i, avmm_readdata_i,
        output req_waitrequest_o, req_readdata_o, avmm_write_o, avmm_read_o,
               avmm_address_o, avmm_writedata_o, avmm_byteenable_o,
               grant_o, timeout_err_o
    );

    modport master (
        output req_write_i, req_read_i, req_address_i, req_writedata_i,
               req_byteenable_i, avmm_waitrequest_i, avmm_readdata_i,
        input  req_waitrequest_o, req_readdata_o, avmm_write_o, avmm_read_o,
               avmm_address_o, avmm_writedata_o, avmm_byteenable_o,
               grant_o, timeout_err_o
    );
endinterface

// File: rtl/avmm_cfg_arbiter.sv
// avmm_cfg_arbiter: round-robin arbiter sharing one AVMM configuration port
// among NUM_REQ requesters. One transfer at a time; the granted requester's
// command is muxed combinationally downstream and its waitrequest follows the
// downstream waitrequest. An IDLE cycle separates consecutive grants.
//
// Optional feature: define AVMM_CFG_ARB_TIMEOUT_EN to enable the stall
// watchdog. A granted transfer that stalls for TIMEOUT_CYCLES cycles is
// aborted: the requester is released with read data 32'hDEAD_BEEF and the
// sticky timeout_err_o is set. Without the macro a stalled transfer waits
// indefinitely and timeout_err_o is tied low.
module avmm_cfg_arbiter #(
    parameter int NUM_REQ        = 2,     // 2..4
    parameter int TIMEOUT_CYCLES = 1024   // 2..65535
) (
    input  logic              clk,
    input  logic              rst_n,
    avmm_cfg_arbiter_if.slave bus
);
    localparam int          IDX_W      = $clog2(NUM_REQ);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;      // index of the granted requester
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;    // where the next search starts
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] grant_oh;
    logic               any_req;
    logic               abort;

    // Command fields of the granted requester
    logic               sel_write;
    logic               sel_read;
    logic [16:0]        sel_address;
    logic [31:0]        sel_writedata;
    logic [3:0]         sel_byteenable;

    assign req_valid = bus.req_write_i | bus.req_read_i;
    assign any_req   = |req_valid;

    // After a finished or aborted transfer the search resumes just past the
    // requester that was served, which is what makes the arbitration fair.
    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    // Round-robin winner: scan offsets from rr_ptr downwards so the smallest
    // offset with an active request is the last assignment and wins.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        winner = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k == (int'(rr_ptr_q) + i) % NUM_REQ && req_valid[k]) begin
                    winner = IDX_W'(k);
                end
            end
        end
    end

    // Select the granted requester's command fields and form the one-hot grant.
    always_comb begin
        sel_write      = 1'b0;
        sel_read       = 1'b0;
        sel_address    = '0;
        sel_writedata  = '0;
        sel_byteenable = '0;
        grant_oh       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == IDX_W'(k)) begin
                sel_write      = bus.req_write_i[k];
                sel_read       = bus.req_read_i[k];
                sel_address    = bus.req_address_i[17*k +: 17];
                sel_writedata  = bus.req_writedata_i[32*k +: 32];
                sel_byteenable = bus.req_byteenable_i[4*k +: 4];
                grant_oh[k]    = (state_q == BUSY);
            end
        end
    end

    // FSM state, grant index and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef AVMM_CFG_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt_q;
    logic        timeout_err_q;

    // The abort cycle is the BUSY cycle in which the stall count has already
    // reached the limit; strobes are withheld and the requester is released.
    assign abort = (state_q == BUSY) && (stall_cnt_q == 16'(TIMEOUT_CYCLES));

    // Stall watchdog: count stalled BUSY cycles, zero while IDLE so every
    // grant starts from 0; remember any abort until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != BUSY) begin
                stall_cnt_q <= '0;
            end else if (bus.avmm_waitrequest_i && !abort) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err_o = timeout_err_q;
`else
    assign abort             = 1'b0;
    assign bus.timeout_err_o = 1'b0;
`endif

    // Next-state logic and bus outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;

        bus.avmm_write_o      = 1'b0;
        bus.avmm_read_o       = 1'b0;
        bus.avmm_address_o    = sel_address;
        bus.avmm_writedata_o  = sel_writedata;
        bus.avmm_byteenable_o = sel_byteenable;
        bus.req_waitrequest_o = '1;
        bus.req_readdata_o    = bus.avmm_readdata_i;
        bus.grant_o           = grant_oh;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    bus.req_waitrequest_o = ~grant_oh;
                    bus.req_readdata_o    = ABORT_DATA;
                    state_d               = IDLE;
                    rr_ptr_d              = next_ptr;
                end else begin
                    // A write wins when both strobes are raised together.
                    bus.avmm_write_o      = sel_write;
                    bus.avmm_read_o       = sel_read & ~sel_write;
                    bus.req_waitrequest_o = ~grant_oh | {NUM_REQ{bus.avmm_waitrequest_i}};
                    if (!sel_write && !sel_read) begin
                        // Requester withdrew mid-transfer: release the port
                        // but keep its turn in the round-robin order.
                        state_d = IDLE;
                    end else if (!bus.avmm_waitrequest_i) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_avmm_cfg_arbiter.sv
// Self-checking bench for avmm_cfg_arbiter with NUM_REQ=2 and
// TIMEOUT_CYCLES=8. A transaction-level reference model (owner index, round
// robin pointer, stall count) predicts every output each cycle; directed
// steps exercise the named scenarios and a randomized phase follows.
module tb_avmm_cfg_arbiter;
    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 8;
`ifdef AVMM_CFG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    avmm_cfg_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    avmm_cfg_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Requester stimulus, held until the model says the transfer is done
    logic        rq_wr   [NUM_REQ];
    logic        rq_rd   [NUM_REQ];
    logic [16:0] rq_addr [NUM_REQ];
    logic [31:0] rq_data [NUM_REQ];
    logic [3:0]  rq_be   [NUM_REQ];
    bit          keep    [NUM_REQ];   // re-request immediately after completion
    logic        dn_wait;
    logic [31:0] dn_rdata;

    // Reference model: who owns the port (-1 = none), where the search starts
    int m_owner;
    int m_ptr;
    int m_stall;
    bit m_err;

    // Observations of the DUT, used by the directed checks
    int                 obs_q[$];
    logic [NUM_REQ-1:0] prev_grant;
    int                 wrq_low [NUM_REQ];
    logic [31:0]        rdata_at_done [NUM_REQ];
    int                 wr_done;
    int                 abort_seen;
    bit                 saw_wr;
    bit                 saw_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int k);
        int kind;
        kind       = $urandom_range(0, 2);
        rq_wr[k]   = (kind != 1);
        rq_rd[k]   = (kind != 0);
        rq_addr[k] = 17'($urandom);
        rq_data[k] = $urandom;
        rq_be[k]   = 4'($urandom);
    endtask

    task automatic set_req(input int k, input logic wr, input logic rd,
                           input logic [16:0] addr, input logic [31:0] data, input logic [3:0] be);
        rq_wr[k] = wr; rq_rd[k] = rd; rq_addr[k] = addr; rq_data[k] = data; rq_be[k] = be;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        for (int k = 0; k < NUM_REQ; k++) begin
            wrq_low[k]       = 0;
            rdata_at_done[k] = '0;
        end
        wr_done = 0; abort_seen = 0; saw_wr = 1'b0; saw_rd = 1'b0;
    endtask

    task automatic apply();
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_write_i[k]             = rq_wr[k];
            bus.req_read_i[k]              = rq_rd[k];
            bus.req_address_i[17*k +: 17]  = rq_addr[k];
            bus.req_writedata_i[32*k +: 32] = rq_data[k];
            bus.req_byteenable_i[4*k +: 4] = rq_be[k];
        end
        bus.avmm_waitrequest_i = dn_wait;
        bus.avmm_readdata_i    = dn_rdata;
    endtask

    // Requester o is released (completed or aborted).
    task automatic finish_xfer(input int o);
        m_ptr   = (o + 1) % NUM_REQ;
        m_owner = -1;
        if (keep[o]) new_req(o);
        else begin
            rq_wr[o] = 1'b0;
            rq_rd[o] = 1'b0;
        end
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model
    // at the posedge.
    task automatic step();
        logic [NUM_REQ-1:0] exp_grant;
        logic [NUM_REQ-1:0] exp_wrq;
        logic               exp_wr;
        logic               exp_rd;
        bit                 abort;
        @(negedge clk);
        apply();
        #1;
        abort     = TO_EN && (m_owner >= 0) && (m_stall == TIMEOUT_CYCLES);
        exp_grant = '0;
        exp_wrq   = '1;
        exp_wr    = 1'b0;
        exp_rd    = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_wrq[m_owner]   = abort ? 1'b0 : dn_wait;
            exp_wr = !abort && rq_wr[m_owner];
            exp_rd = !abort && rq_rd[m_owner] && !rq_wr[m_owner];
        end
        check("grant", 32'(bus.grant_o), 32'(exp_grant));
        check("avmm_write", 32'(bus.avmm_write_o), 32'(exp_wr));
        check("avmm_read", 32'(bus.avmm_read_o), 32'(exp_rd));
        check("waitrequest", 32'(bus.req_waitrequest_o), 32'(exp_wrq));
        check("readdata", bus.req_readdata_o, abort ? 32'hDEAD_BEEF : dn_rdata);
        check("timeout_err", 32'(bus.timeout_err_o), 32'(m_err));
        if (exp_wr || exp_rd) begin
            check("address", 32'(bus.avmm_address_o), 32'(rq_addr[m_owner]));
            check("writedata", bus.avmm_writedata_o, rq_data[m_owner]);
            check("byteenable", 32'(bus.avmm_byteenable_o), 32'(rq_be[m_owner]));
        end
        // Observations
        if (bus.grant_o != '0 && prev_grant == '0) begin
            for (int k = 0; k < NUM_REQ; k++) if (bus.grant_o[k]) obs_q.push_back(k);
        end
        prev_grant = bus.grant_o;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!bus.req_waitrequest_o[k]) begin
                wrq_low[k]++;
                rdata_at_done[k] = bus.req_readdata_o;
            end
        end
        if (bus.avmm_write_o && !dn_wait) wr_done++;
        if (bus.req_readdata_o === 32'hDEAD_BEEF && bus.req_waitrequest_o != '1) abort_seen++;
        saw_wr = saw_wr | bus.avmm_write_o;
        saw_rd = saw_rd | bus.avmm_read_o;
        @(posedge clk);
        // Model update from the rules of the arbiter
        if (m_owner < 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_owner < 0 && (rq_wr[(m_ptr + i) % NUM_REQ] || rq_rd[(m_ptr + i) % NUM_REQ]))
                    m_owner = (m_ptr + i) % NUM_REQ;
            end
            m_stall = 0;
        end else if (abort) begin
            m_err = 1'b1;
            finish_xfer(m_owner);
        end else if (!rq_wr[m_owner] && !rq_rd[m_owner]) begin
            m_owner = -1;
        end else if (!dn_wait) begin
            finish_xfer(m_owner);
        end else begin
            m_stall++;
        end
    endtask

    // Asynchronous reset shortly after a posedge; outputs must drop at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant_o), 32'd0);
        check("rst_write", 32'(bus.avmm_write_o), 32'd0);
        check("rst_read", 32'(bus.avmm_read_o), 32'd0);
        check("rst_waitrequest", 32'(bus.req_waitrequest_o), 32'((1 << NUM_REQ) - 1));
        check("rst_timeout_err", 32'(bus.timeout_err_o), 32'd0);
        m_owner = -1; m_ptr = 0; m_stall = 0; m_err = 1'b0;
        prev_grant = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            set_req(k, 1'b0, 1'b0, '0, '0, '0);
            keep[k] = 1'b0;
        end
        dn_wait = 1'b0; dn_rdata = '0;
        apply();
        clear_obs();
        do_reset();

        // Single write from requester 0, downstream stalls 3 cycles
        set_req(0, 1'b1, 1'b0, 17'h00208, 32'h0000_0001, 4'hF);
        dn_wait = 1'b1;
        step();                      // IDLE, grant registered
        repeat (3) step();           // BUSY, stalled
        dn_wait = 1'b0;
        step();                      // completion
        step();                      // back to IDLE
        check("t1_wrq0_low_cycles", 32'(wrq_low[0]), 32'd1);
        check("t1_write_transfers", 32'(wr_done), 32'd1);

        // Read from requester 1
        clear_obs();
        set_req(1, 1'b0, 1'b1, 17'h1F000, 32'h0, 4'hF);
        dn_rdata = 32'hCAFE_0042;
        dn_wait  = 1'b1;
        step(); step();
        dn_wait = 1'b0;
        step(); step();
        check("t2_readdata", rdata_at_done[1], 32'hCAFE_0042);
        check("t2_wrq1_low_cycles", 32'(wrq_low[1]), 32'd1);
        check("t2_wrq0_stays_high", 32'(wrq_low[0]), 32'd0);

        // Write and read together: write forwarded, read suppressed
        clear_obs();
        set_req(0, 1'b1, 1'b1, 17'h00010, 32'h1234_5678, 4'h3);
        dn_rdata = '0;
        dn_wait  = 1'b1;
        step(); step();
        dn_wait = 1'b0;
        step(); step();
        check("t3_write_seen", 32'(saw_wr), 32'd1);
        check("t3_read_seen", 32'(saw_rd), 32'd0);

        // Requester 1 withdraws mid-transfer: its turn is kept
        set_req(1, 1'b1, 1'b0, 17'h00044, 32'hA5A5_0000, 4'hF);
        dn_wait = 1'b1;
        step(); step();
        set_req(1, 1'b0, 1'b0, 17'h00044, 32'hA5A5_0000, 4'hF);
        step(); step();
        clear_obs();
        keep[0] = 1'b1; keep[1] = 1'b1;
        new_req(0); new_req(1);
        step(); step();
        check("t4_grants_seen", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) check("t4_ptr_kept", 32'(obs_q[0]), 32'd1);
        check("t4_busy_before_reset", 32'(bus.grant_o), 32'b10);

        // Reset in the middle of that transfer, then contention
        do_reset();
        clear_obs();
        for (int c = 0; c < 30; c++) begin
            dn_wait = ($urandom_range(0, 1) == 0);
            if (m_owner >= 0 && m_stall >= 3) dn_wait = 1'b0;
            step();
        end
        check("t5_enough_grants", 32'(obs_q.size() >= 4), 32'd1);
        for (int i = 0; i < obs_q.size() && i < 8; i++) check("t5_rr_order", 32'(obs_q[i]), 32'(i % 2));

`ifdef AVMM_CFG_ARB_TIMEOUT_EN
        // Stall watchdog: abort after 8 stalled cycles, next grant to the other
        do_reset();
        clear_obs();
        new_req(0); new_req(1);
        dn_wait = 1'b1; dn_rdata = '0;
        repeat (TIMEOUT_CYCLES + 4) step();
        check("t6_abort_cycles", 32'(abort_seen), 32'd1);
        check("t6_abort_data", rdata_at_done[0], 32'hDEAD_BEEF);
        check("t6_timeout_err", 32'(bus.timeout_err_o), 32'd1);
        check("t6_grants_seen", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("t6_first_grant", 32'(obs_q[0]), 32'd0);
            check("t6_next_grant", 32'(obs_q[1]), 32'd1);
        end
`else
        // No watchdog: a stalled transfer holds the grant indefinitely
        do_reset();
        clear_obs();
        new_req(0); new_req(1);
        dn_wait = 1'b1; dn_rdata = '0;
        repeat (30) step();
        check("t6_grants_seen", 32'(obs_q.size()), 32'd1);
        check("t6_no_abort", 32'(abort_seen), 32'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            keep[k] = 1'b0;
            rq_wr[k] = 1'b0;
            rq_rd[k] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!rq_wr[k] && !rq_rd[k] && $urandom_range(0, 2) == 0) new_req(k);
            end
            dn_wait = ($urandom_range(0, 1) == 0);
            if (m_owner >= 0 && m_stall >= TIMEOUT_CYCLES - 3) dn_wait = 1'b0;
            dn_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
